f32_hex_char_streamer: RTL and testbench
========================================

Name: f32_hex_char_streamer

Overview:
Converts a 32-bit IEEE-754 single-precision value into a fixed 12-character ASCII field string, in the same sign / exponent / mantissa split the user edits on the keypad. The string is streamed one character per handshake to a character-display writer such as the LCD line driver. It runs in the opposite direction to the keypad nibble-assembly path: the keypad path builds a float from hex nibbles, and this block takes a float back to hex characters. One instance serves one display row. The top level triggers it whenever A, B or the adder/subtractor result changes.

Parameters:
SEP_CHAR, 8'h20, separator character emitted at indices 1 and 4.
LOWERCASE, 0, 0 emits hex digits A-F as 8'h41-46; 1 emits a-f as 8'h61-66.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  request to format VALUE; sampled only in IDLE.
VALUE  input  32  float to format; latched on the accepted START.
OVF  input  1  overflow flag from the adder/subtractor; latched with VALUE.
UNF  input  1  underflow flag from the adder/subtractor; latched with VALUE.
CHAR  output  8  ASCII character currently offered.
CHAR_VALID  output  1  CHAR is valid.
CHAR_READY  input  1  the consumer accepts CHAR on an edge where VALID and READY are both 1.
CHAR_IDX  output  4  index (0-11) of the character currently offered.
BUSY  output  1  high while in SEND.
DONE  output  1  one-cycle pulse after the last character is accepted.

Behaviour:
- Reset values: state=IDLE, CHAR=8'h00, CHAR_VALID=0, CHAR_IDX=0, BUSY=0, DONE=0. Latched value and flags are cleared to 0.
- Reset has priority over every other input. RESET asserted mid-stream:
  - the next edge forces IDLE with CHAR_VALID=0;
  - the partial string is abandoned and no DONE is issued.
- States are IDLE, SEND and FIN.
- IDLE:
  - START=1 at edge k latches VALUE, OVF and UNF, and sets CHAR_IDX=0.
  - The state moves to SEND, and CHAR_VALID=1 with the index-0 character is visible after edge k (one-cycle latency).
- SEND:
  - If VALID and READY are both 1 at an edge, CHAR_IDX advances and the next character is presented on the following cycle, so back-to-back transfers run at 1 char/cycle.
  - If READY=0, CHAR and CHAR_IDX hold stable and VALID stays 1. VALID never drops without an acceptance.
  - When index 11 is accepted, the state moves to FIN and CHAR_VALID=0.
  - START is ignored in SEND. VALUE, OVF and UNF changes during SEND have no effect (they were latched at START).
- FIN:
  - Lasts exactly one cycle with DONE=1 and BUSY=0, then returns to IDLE.
  - START during FIN is ignored.
- Character map, with s=v[31], e=v[30:23], m={1'b0,v[22:0]}:
  - 0: '+' (2B) if s=0, '-' (2D) if s=1.
  - 1: SEP_CHAR.
  - 2: hex(e[7:4]); 3: hex(e[3:0]).
  - 4: SEP_CHAR.
  - 5: hex(m[23:20]), always 0-7.
  - 6: hex(m[19:16]); 7: hex(m[15:12]); 8: hex(m[11:8]); 9: hex(m[7:4]); 10: hex(m[3:0]).
  - 11: status character, chosen by the first rule that matches:
    - 'N' (4E) if e=FF and m!=0;
    - 'I' (49) if e=FF and m=0;
    - 'O' (4F) if OVF;
    - 'U' (55) if UNF;
    - 'Z' (5A) if e=0 and m!=0 (denormal);
    - otherwise SEP_CHAR.
- hex(n): n<10 gives 8'h30+n; n>=10 gives 8'h41+n-10 when LOWERCASE=0, or 8'h61+n-10 when LOWERCASE=1.
- CHAR is registered. CHAR_IDX and CHAR always refer to the same character.

Test Plan:
- VALUE=32'h3FC00000, READY held 1, START pulse
  -> chars 2B 20 37 46 20 34 30 30 30 30 30 20 ("+ 7F 400000 ") on 12 consecutive cycles.
  -> DONE pulses on the cycle after idx 11 is accepted; BUSY is high for exactly 12 cycles.
- VALUE=32'hC0490FDB
  -> "- 80 490FDB ".
- VALUE=32'hC0490FDB with LOWERCASE=1
  -> "- 80 490fdb ".
- Status priority:
  - VALUE=32'h7F800000 -> "+ FF 000000I".
  - VALUE=32'h7FC00000 with OVF=1 -> status 'N' (NaN wins over OVF).
  - VALUE=32'h00000001 -> "+ 00 000001Z".
  - VALUE=32'h3F800000 with UNF=1 -> status 'U'.
- Backpressure: READY=0 for 5 cycles while idx=3 is offered
  -> CHAR=0x46 and IDX=3 are stable and VALID=1 throughout; idx 4 appears on the cycle after READY rises.
- START and VALUE changes during SEND
  -> ignored; the original string completes.
- RESET at idx 6
  -> next cycle VALID=0, IDX=0, BUSY=0, no DONE.
  -> A fresh START then produces a complete string from idx 0.

Source files
------------

// File: rtl/f32_hex_char_streamer.sv
// f32_hex_char_streamer: formats an IEEE-754 single-precision value as a fixed
// 12-character ASCII field ("s EE MMMMMMx") and streams it one character per
// valid/ready handshake to a character-display writer.
module f32_hex_char_streamer #(
    parameter logic [7:0] SEP_CHAR  = 8'h20,
    parameter bit         LOWERCASE = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] VALUE,
    input  logic        OVF,
    input  logic        UNF,
    output logic [7:0]  CHAR,
    output logic        CHAR_VALID,
    input  logic        CHAR_READY,
    output logic [3:0]  CHAR_IDX,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned VALUE_W = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(11);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [VALUE_W-1:0]  value_q, value_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [CHAR_W-1:0]   char_d;
    logic                valid_d;
    logic [IDX_W-1:0]    idx_d;
    logic                busy_d;
    logic                done_d;

    // One nibble to its ASCII hex digit; letter case chosen at elaboration.
    function automatic logic [CHAR_W-1:0] hex_char(input logic [3:0] n);
        logic [CHAR_W-1:0] base;
        base = LOWERCASE ? 8'h61 : 8'h41;
        if (n < 4'd10) begin
            return 8'h30 + CHAR_W'(n);
        end
        return base + CHAR_W'(n - 4'd10);
    endfunction

    // Character at field position idx for the given value and status flags.
    function automatic logic [CHAR_W-1:0] field_char(
        input logic [IDX_W-1:0]   idx,
        input logic [VALUE_W-1:0] v,
        input logic               ovf,
        input logic               unf
    );
        logic [7:0]        e;
        logic [23:0]       m;
        logic [CHAR_W-1:0] c;
        e = v[30:23];
        m = {1'b0, v[22:0]};
        c = SEP_CHAR;
        case (idx)
            4'd0:  c = v[31] ? 8'h2D : 8'h2B;
            4'd2:  c = hex_char(e[7:4]);
            4'd3:  c = hex_char(e[3:0]);
            4'd5:  c = hex_char(m[23:20]);
            4'd6:  c = hex_char(m[19:16]);
            4'd7:  c = hex_char(m[15:12]);
            4'd8:  c = hex_char(m[11:8]);
            4'd9:  c = hex_char(m[7:4]);
            4'd10: c = hex_char(m[3:0]);
            4'd11: begin
                // Status priority: NaN, Inf, overflow, underflow, denormal.
                if (e == 8'hFF && m != 24'd0)      c = 8'h4E;
                else if (e == 8'hFF)               c = 8'h49;
                else if (ovf)                      c = 8'h4F;
                else if (unf)                      c = 8'h55;
                else if (e == 8'h00 && m != 24'd0) c = 8'h5A;
                else                               c = SEP_CHAR;
            end
            default: c = SEP_CHAR;
        endcase
        return c;
    endfunction

    // Next-state and next-output logic; everything holds unless a case changes it.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        char_d  = CHAR;
        valid_d = CHAR_VALID;
        idx_d   = CHAR_IDX;
        busy_d  = BUSY;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (START) begin
                    value_d = VALUE;
                    ovf_d   = OVF;
                    unf_d   = UNF;
                    idx_d   = '0;
                    char_d  = field_char('0, VALUE, OVF, UNF);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (CHAR_VALID && CHAR_READY) begin
                    if (CHAR_IDX == LAST_IDX) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        idx_d  = CHAR_IDX + IDX_W'(1);
                        char_d = field_char(CHAR_IDX + IDX_W'(1), value_q, ovf_q, unf_q);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latched operand and registered outputs; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            value_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            CHAR       <= '0;
            CHAR_VALID <= 1'b0;
            CHAR_IDX   <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            CHAR       <= char_d;
            CHAR_VALID <= valid_d;
            CHAR_IDX   <= idx_d;
            BUSY       <= busy_d;
            DONE       <= done_d;
        end
    end

endmodule

// File: tb/tb_f32_hex_char_streamer.sv
// Directed bench for f32_hex_char_streamer: expected strings are hand-computed.
module tb_f32_hex_char_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        ovf;
    logic        unf;
    logic        ready;
    logic [7:0]  char_u, char_l;
    logic        valid_u, valid_l;
    logic [3:0]  idx_u, idx_l;
    logic        busy_u, busy_l;
    logic        done_u, done_l;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    f32_hex_char_streamer #(.SEP_CHAR(8'h20), .LOWERCASE(1'b0)) dut (
        .CLK(clk), .RESET(reset), .START(start), .VALUE(value), .OVF(ovf), .UNF(unf),
        .CHAR(char_u), .CHAR_VALID(valid_u), .CHAR_READY(ready), .CHAR_IDX(idx_u),
        .BUSY(busy_u), .DONE(done_u)
    );

    f32_hex_char_streamer #(.SEP_CHAR(8'h20), .LOWERCASE(1'b1)) dut_lc (
        .CLK(clk), .RESET(reset), .START(start), .VALUE(value), .OVF(ovf), .UNF(unf),
        .CHAR(char_l), .CHAR_VALID(valid_l), .CHAR_READY(ready), .CHAR_IDX(idx_l),
        .BUSY(busy_l), .DONE(done_l)
    );

    function automatic logic [7:0] byte_at(input logic [95:0] s, input int i);
        return s[95-8*i -: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_value(input logic [31:0] v, input logic o, input logic u);
        start = 1'b1;
        value = v;
        ovf   = o;
        unf   = u;
        step();
        start = 1'b0;
    endtask

    task automatic expect_char(input int i, input logic [7:0] c);
        check($sformatf("valid[%0d]", i), 32'(valid_u), 32'd1);
        check($sformatf("idx[%0d]", i), 32'(idx_u), 32'(i));
        check($sformatf("char[%0d]", i), 32'(char_u), 32'(c));
        check($sformatf("busy[%0d]", i), 32'(busy_u), 32'd1);
        check($sformatf("done_low[%0d]", i), 32'(done_u), 32'd0);
    endtask

    task automatic expect_done();
        check("done_pulse", 32'(done_u), 32'd1);
        check("fin_valid", 32'(valid_u), 32'd0);
        check("fin_busy", 32'(busy_u), 32'd0);
        step();
        check("done_clear", 32'(done_u), 32'd0);
        check("idle_valid", 32'(valid_u), 32'd0);
        check("idle_busy", 32'(busy_u), 32'd0);
    endtask

    task automatic stream(input logic [31:0] v, input logic o, input logic u,
                          input logic [95:0] exp, input bit chk_l, input logic [95:0] exp_l);
        ready = 1'b1;
        start_value(v, o, u);
        for (int i = 0; i < 12; i++) begin
            expect_char(i, byte_at(exp, i));
            if (chk_l) check($sformatf("lc_char[%0d]", i), 32'(char_l), 32'(byte_at(exp_l, i)));
            step();
        end
        expect_done();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        ovf   = 1'b0;
        unf   = 1'b0;
        ready = 1'b1;
        step();
        step();
        check("rst_char", 32'(char_u), 32'h00);
        check("rst_valid", 32'(valid_u), 32'd0);
        check("rst_idx", 32'(idx_u), 32'd0);
        check("rst_busy", 32'(busy_u), 32'd0);
        check("rst_done", 32'(done_u), 32'd0);
        reset = 1'b0;
        step();

        // "+ 7F 400000 "
        stream(32'h3FC00000, 1'b0, 1'b0, 96'h2B2037462034303030303020, 1'b0, '0);
        // "- 80 490FDB " and lowercase "- 80 490fdb "
        stream(32'hC0490FDB, 1'b0, 1'b0, 96'h2D2038302034393046444220,
               1'b1, 96'h2D2038302034393066646220);
        // "+ FF 000000I"
        stream(32'h7F800000, 1'b0, 1'b0, 96'h2B2046462030303030303049, 1'b1,
               96'h2B2066662030303030303049);
        // NaN beats OVF: "+ FF 400000N"
        stream(32'h7FC00000, 1'b1, 1'b0, 96'h2B204646203430303030304E, 1'b0, '0);
        // Denormal: "+ 00 000001Z"
        stream(32'h00000001, 1'b0, 1'b0, 96'h2B203030203030303030315A, 1'b0, '0);
        // UNF on a normal value: "+ 7F 000000U"
        stream(32'h3F800000, 1'b0, 1'b1, 96'h2B2037462030303030303055, 1'b0, '0);

        // Backpressure while idx 3 is offered
        ready = 1'b1;
        start_value(32'h3FC00000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_char(i, byte_at(96'h2B2037462034303030303020, i));
            step();
        end
        ready = 1'b0;
        expect_char(3, 8'h46);
        for (int k = 0; k < 5; k++) begin
            step();
            expect_char(3, 8'h46);
        end
        ready = 1'b1;
        step();
        expect_char(4, 8'h20);
        step();
        for (int i = 5; i < 12; i++) begin
            expect_char(i, byte_at(96'h2B2037462034303030303020, i));
            step();
        end
        expect_done();

        // START and VALUE/OVF changes during SEND and START in FIN are ignored
        start_value(32'h3FC00000, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            expect_char(i, byte_at(96'h2B2037462034303030303020, i));
            if (i == 5) begin
                start = 1'b1;
                value = 32'hFFFFFFFF;
                ovf   = 1'b1;
            end
            step();
            start = 1'b0;
        end
        check("fin_done", 32'(done_u), 32'd1);
        start = 1'b1;
        value = 32'h3F800000;
        ovf   = 1'b0;
        step();
        start = 1'b0;
        check("fin_start_done", 32'(done_u), 32'd0);
        check("fin_start_valid", 32'(valid_u), 32'd0);
        check("fin_start_busy", 32'(busy_u), 32'd0);
        step();
        check("fin_start_idle", 32'(valid_u), 32'd0);

        // Reset mid-stream at idx 6
        start_value(32'hC0490FDB, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            expect_char(i, byte_at(96'h2D2038302034393046444220, i));
            step();
        end
        expect_char(6, 8'h39);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", 32'(valid_u), 32'd0);
        check("mid_rst_idx", 32'(idx_u), 32'd0);
        check("mid_rst_busy", 32'(busy_u), 32'd0);
        check("mid_rst_done", 32'(done_u), 32'd0);
        step();
        check("mid_rst_no_done", 32'(done_u), 32'd0);
        check("mid_rst_idle", 32'(valid_u), 32'd0);
        stream(32'h00000001, 1'b0, 1'b0, 96'h2B203030203030303030315A, 1'b0, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
